// File: rtl/pam4_dfe_slicer.sv
// PAM-4 receive slicer with 1-tap decision feedback and BER counters.
// The previous decision's ideal level, scaled by 2^-H1_SHIFT, is subtracted
// from each incoming sample. The result is sliced to a 2-bit symbol and
// compared against the reference symbol once the warm-up window has elapsed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WARMUP | counting off; valid symbols fill the skip window
// ST_COUNT  | every valid symbol counted, mismatches counted as errors
module pam4_dfe_slicer #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int H1_SHIFT          = 1,
    parameter int SKIP_SYMBOLS      = 4,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic [1:0]                          ref_symbol,
    input  logic                                dfe_en,
    input  logic                                clear_counts,
    output logic [1:0]                          symbol_out,
    output logic signed [SIGNAL_RESOLUTION-1:0] eq_out,
    output logic                                symbol_out_valid,
    output logic [COUNT_WIDTH-1:0]              symbol_count,
    output logic [COUNT_WIDTH-1:0]              error_count,
    output logic                                counting
);

    // Two guard bits so signal_in minus the largest feedback cannot overflow.
    localparam int EW        = SIGNAL_RESOLUTION + 2;
    localparam int LVL_OUTER = (3 * SYMBOL_SEPERATION) / 2;
    localparam int LVL_INNER = SYMBOL_SEPERATION / 2;

    localparam logic signed [EW-1:0] LVL_0   = EW'(-LVL_OUTER);
    localparam logic signed [EW-1:0] LVL_1   = EW'(-LVL_INNER);
    localparam logic signed [EW-1:0] LVL_2   = EW'(LVL_INNER);
    localparam logic signed [EW-1:0] LVL_3   = EW'(LVL_OUTER);
    localparam logic signed [EW-1:0] THR_POS = EW'(SYMBOL_SEPERATION);
    localparam logic signed [EW-1:0] THR_NEG = EW'(-SYMBOL_SEPERATION);
    localparam logic signed [EW-1:0] ZERO    = '0;
    localparam logic signed [EW-1:0] EQ_MAX  = EW'((2 ** (SIGNAL_RESOLUTION - 1)) - 1);
    localparam logic signed [EW-1:0] EQ_MIN  = EW'(-(2 ** (SIGNAL_RESOLUTION - 1)));

    localparam int SKW = (SKIP_SYMBOLS > 0) ? $clog2(SKIP_SYMBOLS + 1) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_SYMBOLS > 0) ? SKIP_SYMBOLS - 1 : 0);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_COUNT  = 1'b1;
    // With no warm-up window the block comes out of reset/clear already counting.
    localparam logic [0:0] ST_START  = (SKIP_SYMBOLS == 0) ? ST_COUNT : ST_WARMUP;

    logic [1:0]              prev_sym;
    logic                    prev_ok;
    logic [0:0]              state;
    logic [SKW-1:0]          skip_cnt;
    logic signed [EW-1:0]    signal_ext;
    logic signed [EW-1:0]    lvl_prev;
    logic signed [EW-1:0]    fb;
    logic signed [EW-1:0]    eq;
    logic [1:0]              decision;
    logic signed [SIGNAL_RESOLUTION-1:0] eq_sat;

    assign signal_ext = EW'(signal_in);
    assign counting   = (state == ST_COUNT);

    // Ideal level of the previous decision, then the scaled feedback term.
    always_comb begin
        lvl_prev = LVL_0;
        case (prev_sym)
            2'd0:    lvl_prev = LVL_0;
            2'd1:    lvl_prev = LVL_1;
            2'd2:    lvl_prev = LVL_2;
            default: lvl_prev = LVL_3;
        endcase
        fb = (dfe_en && prev_ok) ? (lvl_prev >>> H1_SHIFT) : ZERO;
        eq = signal_ext - fb;
    end

    // Slice the equalized sample and clamp it to the output range.
    always_comb begin
        decision = 2'd3;
        if (eq < THR_NEG)      decision = 2'd0;
        else if (eq < ZERO)    decision = 2'd1;
        else if (eq < THR_POS) decision = 2'd2;

        eq_sat = eq[SIGNAL_RESOLUTION-1:0];
        if (eq > EQ_MAX)      eq_sat = EQ_MAX[SIGNAL_RESOLUTION-1:0];
        else if (eq < EQ_MIN) eq_sat = EQ_MIN[SIGNAL_RESOLUTION-1:0];
    end

    // Output registers and decision history; values hold across valid gaps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            symbol_out       <= 2'd0;
            eq_out           <= '0;
            symbol_out_valid <= 1'b0;
            prev_sym         <= 2'd0;
            prev_ok          <= 1'b0;
        end else begin
            symbol_out_valid <= signal_in_valid;
            if (signal_in_valid) begin
                symbol_out <= decision;
                eq_out     <= eq_sat;
                prev_sym   <= decision;
                prev_ok    <= 1'b1;
            end
        end
    end

    // Warm-up / count FSM with saturating counters; clear beats a valid symbol.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_START;
            skip_cnt     <= '0;
            symbol_count <= '0;
            error_count  <= '0;
        end else if (clear_counts) begin
            state        <= ST_START;
            skip_cnt     <= '0;
            symbol_count <= '0;
            error_count  <= '0;
        end else if (signal_in_valid) begin
            case (state)
                ST_WARMUP: begin
                    skip_cnt <= skip_cnt + SKW'(1);
                    if (skip_cnt == SKIP_LAST) state <= ST_COUNT;
                end
                default: begin
                    if (symbol_count != '1) symbol_count <= symbol_count + COUNT_WIDTH'(1);
                    if ((decision != ref_symbol) && (error_count != '1))
                        error_count <= error_count + COUNT_WIDTH'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pam4_dfe_slicer.sv
// Bench for pam4_dfe_slicer: a default instance plus a COUNT_WIDTH=4 instance
// sharing the same stimulus, compared against an integer reference model.
module tb_pam4_dfe_slicer;

    localparam int N    = 8;
    localparam int S    = 56;
    localparam int H1   = 1;
    localparam int SKIP = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic signed [N-1:0] signal_in = '0;
    logic              signal_in_valid = 1'b0;
    logic [1:0]        ref_symbol = 2'd0;
    logic              dfe_en = 1'b1;
    logic              clear_counts = 1'b0;

    logic [1:0]        symbol_out, symbol_out_4;
    logic signed [N-1:0] eq_out, eq_out_4;
    logic              symbol_out_valid, symbol_out_valid_4;
    logic [31:0]       symbol_count, error_count;
    logic [3:0]        symbol_count_4, error_count_4;
    logic              counting, counting_4;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit     m_has_prev;
    int     m_prev;
    int     m_sym;
    int     m_eq;
    bit     m_valid;
    int     m_skip;
    longint m_sc;
    longint m_ec;
    bit     m_counting;

    pam4_dfe_slicer dut (
        .clk(clk), .rstn(rstn), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
        .ref_symbol(ref_symbol), .dfe_en(dfe_en), .clear_counts(clear_counts),
        .symbol_out(symbol_out), .eq_out(eq_out), .symbol_out_valid(symbol_out_valid),
        .symbol_count(symbol_count), .error_count(error_count), .counting(counting)
    );

    pam4_dfe_slicer #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
        .ref_symbol(ref_symbol), .dfe_en(dfe_en), .clear_counts(clear_counts),
        .symbol_out(symbol_out_4), .eq_out(eq_out_4), .symbol_out_valid(symbol_out_valid_4),
        .symbol_count(symbol_count_4), .error_count(error_count_4), .counting(counting_4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic int level(input int s);
        case (s)
            0: return -(3 * S) / 2;
            1: return -S / 2;
            2: return S / 2;
            default: return (3 * S) / 2;
        endcase
    endfunction

    function automatic int slice(input int e);
        if (e < -S) return 0;
        if (e < 0)  return 1;
        if (e < S)  return 2;
        return 3;
    endfunction

    function automatic int clamp(input int e);
        if (e > 127)  return 127;
        if (e < -128) return -128;
        return e;
    endfunction

    function automatic longint csat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_has_prev = 0; m_prev = 0; m_sym = 0; m_eq = 0; m_valid = 0;
        m_skip = 0; m_sc = 0; m_ec = 0; m_counting = (SKIP == 0);
    endtask

    // Drive one cycle of inputs, advance the model, leave time at posedge+1.
    task automatic step(input bit v, input int x, input int r, input bit en, input bit clr);
        int fb, e, d;
        signal_in = N'(x); signal_in_valid = v; ref_symbol = 2'(r);
        dfe_en = en; clear_counts = clr;
        @(posedge clk);
        m_valid = v;
        d = 0;
        if (v) begin
            fb = (en && m_has_prev) ? (level(m_prev) >>> H1) : 0;
            e = x - fb;
            d = slice(e);
            m_sym = d; m_eq = clamp(e);
            m_has_prev = 1; m_prev = d;
        end
        if (clr) begin
            m_skip = 0; m_sc = 0; m_ec = 0; m_counting = (SKIP == 0);
        end else if (v) begin
            if (m_counting) begin
                m_sc++;
                if (d != r) m_ec++;
            end else begin
                m_skip++;
                if (m_skip == SKIP) m_counting = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        signal_in_valid = 0; clear_counts = 0;
        rstn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (symbol_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0d want 0", symbol_out_valid); end
        checks++; if (symbol_out !== 2'd0) begin failures++; $display("FAIL reset_symbol: got %0d want 0", symbol_out); end
        checks++; if (eq_out !== 8'sd0) begin failures++; $display("FAIL reset_eq: got %0d want 0", eq_out); end
        checks++; if (symbol_count !== 32'd0 || error_count !== 32'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d want 0/0", symbol_count, error_count); end
        checks++; if (counting !== 1'b0) begin failures++; $display("FAIL reset_counting: got %0d want 0", counting); end
    endtask

    task automatic test_ideal_levels();
        int xs[4] = '{-84, -28, 28, 84};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            step(1, xs[k], k, 1, 0);
            checks++; if (symbol_out !== 2'(k) || symbol_out !== 2'(m_sym)) begin failures++; $display("FAIL ideal_symbol[%0d]: got %0d want %0d", k, symbol_out, k); end
            checks++; if (eq_out !== 8'(xs[k])) begin failures++; $display("FAIL ideal_eq[%0d]: got %0d want %0d", k, eq_out, xs[k]); end
            checks++; if (symbol_out_valid !== 1'b1) begin failures++; $display("FAIL ideal_valid[%0d]: got %0d want 1", k, symbol_out_valid); end
            step(0, 0, 0, 1, 0);
            checks++; if (symbol_out_valid !== 1'b0 || symbol_out !== 2'(k) || eq_out !== 8'(xs[k])) begin
                failures++; $display("FAIL ideal_hold[%0d]: got v=%0d s=%0d eq=%0d want v=0 s=%0d eq=%0d", k, symbol_out_valid, symbol_out, eq_out, k, xs[k]);
            end
        end
    endtask

    task automatic test_channel_dfe();
        do_reset();
        step(1, 84, 3, 1, 0);
        step(1, 70, 2, 1, 0);
        checks++; if (eq_out !== 8'sd28 || eq_out !== 8'(m_eq)) begin failures++; $display("FAIL dfe_on_eq: got %0d want 28", eq_out); end
        checks++; if (symbol_out !== 2'd2) begin failures++; $display("FAIL dfe_on_symbol: got %0d want 2", symbol_out); end
        do_reset();
        step(1, 84, 3, 0, 0);
        step(1, 70, 2, 0, 0);
        checks++; if (eq_out !== 8'sd70) begin failures++; $display("FAIL dfe_off_eq: got %0d want 70", eq_out); end
        checks++; if (symbol_out !== 2'd3) begin failures++; $display("FAIL dfe_off_symbol: got %0d want 3", symbol_out); end
        // feedback reenabled on the same valid cycle, after a gap
        step(0, 0, 0, 0, 0);
        step(1, 70, 2, 1, 0);
        checks++; if (eq_out !== 8'(m_eq) || symbol_out !== 2'(m_sym)) begin failures++; $display("FAIL dfe_toggle: got eq=%0d s=%0d want eq=%0d s=%0d", eq_out, symbol_out, m_eq, m_sym); end
    endtask

    task automatic test_thresholds();
        int xs[6] = '{-57, -56, -1, 0, 55, 56};
        int ws[6] = '{0, 1, 1, 2, 2, 3};
        for (int k = 0; k < 6; k++) begin
            do_reset();
            step(1, xs[k], 0, 1, 0);
            checks++; if (symbol_out !== 2'(ws[k]) || symbol_out !== 2'(m_sym)) begin failures++; $display("FAIL threshold[%0d]: in=%0d got %0d want %0d", k, xs[k], symbol_out, ws[k]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1, -84, 0, 1, 0);
        step(1, 127, 3, 1, 0);
        checks++; if (eq_out !== 8'sd127) begin failures++; $display("FAIL sat_high_eq: got %0d want 127", eq_out); end
        checks++; if (symbol_out !== 2'd3) begin failures++; $display("FAIL sat_high_symbol: got %0d want 3", symbol_out); end
        step(1, 84, 3, 1, 0);
        step(1, -128, 0, 1, 0);
        checks++; if (eq_out !== -8'sd128 || symbol_out !== 2'd0) begin failures++; $display("FAIL sat_low: got eq=%0d s=%0d want -128/0", eq_out, symbol_out); end
    endtask

    task automatic test_counting();
        int tx, r;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tx = int'($urandom_range(0, 3));
            r = (k == 5 || k == 8) ? (tx + 1) % 4 : tx;
            step(1, level(tx) + int'($urandom_range(0, 20)) - 10, r, 0, 0);
            if (k % 3 == 1) step(0, 0, 0, 0, 0);
        end
        checks++; if (symbol_count !== 32'd6 || symbol_count !== 32'(m_sc)) begin failures++; $display("FAIL count_symbols: got %0d want 6", symbol_count); end
        checks++; if (error_count !== 32'd2) begin failures++; $display("FAIL count_errors: got %0d want 2", error_count); end
        checks++; if (counting !== 1'b1) begin failures++; $display("FAIL count_state: got %0d want 1", counting); end
        step(1, 28, 0, 0, 1);
        checks++; if (symbol_count !== 32'd0 || error_count !== 32'd0 || counting !== 1'b0) begin
            failures++; $display("FAIL clear_counts: got %0d/%0d/%0d want 0/0/0", symbol_count, error_count, counting);
        end
        checks++; if (symbol_out_valid !== 1'b1 || symbol_out !== 2'd2) begin failures++; $display("FAIL clear_decides: got v=%0d s=%0d want 1/2", symbol_out_valid, symbol_out); end
        // the symbol under clear must not count toward warm-up
        for (int k = 0; k < SKIP; k++) step(1, 28, 2, 0, 0);
        checks++; if (counting !== 1'b1 || symbol_count !== 32'd0) begin failures++; $display("FAIL warmup_after_clear: got c=%0d n=%0d want 1/0", counting, symbol_count); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 8; k++) step(1, 84, 3, 1, 0);
        #2 signal_in_valid = 0;
        rstn = 0;
        #1;
        checks++; if (symbol_out !== 2'd0 || eq_out !== 8'sd0 || symbol_out_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_outputs: got s=%0d eq=%0d v=%0d want 0", symbol_out, eq_out, symbol_out_valid);
        end
        checks++; if (symbol_count !== 32'd0 || error_count_4 !== 4'd0 || symbol_count_4 !== 4'd0 || counting !== 1'b0) begin
            failures++; $display("FAIL async_reset_counts: got %0d/%0d/%0d want 0", symbol_count, symbol_count_4, counting);
        end
        model_reset();
        @(posedge clk); #1 rstn = 1;
        step(1, 50, 2, 1, 0);
        checks++; if (eq_out !== 8'sd50 || symbol_out !== 2'd2) begin failures++; $display("FAIL reset_history: got eq=%0d s=%0d want 50/2", eq_out, symbol_out); end
    endtask

    task automatic test_count_saturation();
        int tx;
        do_reset();
        for (int k = 0; k < SKIP; k++) step(1, 84, 3, 0, 0);
        for (int k = 0; k < 20; k++) begin
            tx = int'($urandom_range(0, 3));
            step(1, level(tx), (tx + 1) % 4, 0, 0);
        end
        checks++; if (error_count_4 !== 4'd15 || symbol_count_4 !== 4'd15) begin failures++; $display("FAIL sat4_counts: got %0d/%0d want 15/15", symbol_count_4, error_count_4); end
        checks++; if (error_count !== 32'd20 || error_count !== 32'(m_ec)) begin failures++; $display("FAIL sat32_errors: got %0d want 20", error_count); end
        for (int k = 0; k < 3; k++) step(1, 28, 0, 0, 0);
        checks++; if (error_count_4 !== 4'd15) begin failures++; $display("FAIL sat4_hold: got %0d want 15", error_count_4); end
        checks++; if (error_count !== 32'd23) begin failures++; $display("FAIL sat32_continue: got %0d want 23", error_count); end
    endtask

    task automatic test_random();
        int tx, prev_tx, x, r;
        bit v, en, clr;
        do_reset();
        prev_tx = 0;
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 60) == 0);
            tx = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) x = int'($urandom_range(0, 255)) - 128;
            else x = clamp(level(tx) + (level(prev_tx) >>> 1) + int'($urandom_range(0, 16)) - 8);
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : tx;
            if (v) prev_tx = tx;
            step(v, x, r, en, clr);
            checks++; if (symbol_out_valid !== m_valid || symbol_out !== 2'(m_sym) || eq_out !== 8'(m_eq)) begin
                failures++; $display("FAIL rand_data[%0d]: got v=%0d s=%0d eq=%0d want v=%0d s=%0d eq=%0d", k, symbol_out_valid, symbol_out, eq_out, m_valid, m_sym, m_eq);
            end
            checks++; if (symbol_count !== 32'(csat(m_sc, 32)) || error_count !== 32'(csat(m_ec, 32)) || counting !== m_counting) begin
                failures++; $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, symbol_count, error_count, counting, m_sc, m_ec, m_counting);
            end
            checks++; if (symbol_count_4 !== 4'(csat(m_sc, 4)) || error_count_4 !== 4'(csat(m_ec, 4)) || counting_4 !== m_counting) begin
                failures++; $display("FAIL rand_counts4[%0d]: got %0d/%0d want %0d/%0d", k, symbol_count_4, error_count_4, csat(m_sc, 4), csat(m_ec, 4));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ideal_levels();
        test_channel_dfe();
        test_thresholds();
        test_saturation();
        test_counting();
        test_reset_midstream();
        test_count_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
